// File: rtl/iaxi_auto_load.sv
// ITCM auto-load fetcher: issues single-beat word reads on an AXI read
// channel, forwards returned words in order and reports completion/errors.
module iaxi_auto_load #(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           MAX_OUTSTANDING = 4,
  parameter logic [ADDR_WIDTH-1:0] LOAD_END_ADDR   = ADDR_WIDTH'(32'h0000_7FFC)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  itcm_auto_load,
  input  logic [ADDR_WIDTH-1:0] itcm_auto_load_addr,
  output logic                  IAXI_ready,
  output logic [DATA_WIDTH-1:0] IAXI_read_data,
  output logic                  IAXI_read_data_valid,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int unsigned      CNT_W   = 3;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GAP   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             arvalid_nxt;
  logic             araddr_ld;
  logic [CNT_W-1:0] outstanding, outstanding_nxt;
  logic             ar_hs;
  logic             r_acc;
  logic             r_bad;
  logic             can_issue;

  // Fixed burst shape: one 32-bit beat, incrementing; R is always accepted.
  assign m_arlen   = 8'd0;
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign m_rready  = 1'b1;

  assign ar_hs      = m_arvalid & m_arready;
  assign IAXI_ready = ar_hs;
  assign can_issue  = (outstanding < MAX_CNT);
  // A beat is only consumed when a read is actually pending.
  assign r_acc      = m_rvalid & (outstanding != '0);
  assign r_bad      = (m_rvalid & (outstanding == '0)) |
                      (r_acc & ((m_rresp != 2'b00) | ~m_rlast));

  // Next-state, request valid and address-load decisions.
  always_comb begin
    state_nxt   = state;
    arvalid_nxt = m_arvalid;
    araddr_ld   = 1'b0;
    case (state)
      IDLE: begin
        if (itcm_auto_load) begin
          state_nxt   = LOAD;
          araddr_ld   = 1'b1;
          arvalid_nxt = can_issue;
        end
      end
      LOAD: begin
        if (m_arvalid) begin
          if (m_arready) begin
            arvalid_nxt = 1'b0;
            state_nxt   = (m_araddr == LOAD_END_ADDR) ? DRAIN : GAP;
          end
        end else if (!itcm_auto_load) begin
          state_nxt = DRAIN;
        end else begin
          arvalid_nxt = can_issue;
        end
      end
      GAP: begin
        if (!itcm_auto_load) begin
          state_nxt = DRAIN;
        end else begin
          state_nxt   = LOAD;
          araddr_ld   = 1'b1;
          arvalid_nxt = can_issue;
        end
      end
      DRAIN: begin
        arvalid_nxt = 1'b0;
        if (outstanding == '0) state_nxt = DONE;
      end
      DONE: begin
        arvalid_nxt = 1'b0;
      end
      default: begin
        state_nxt   = IDLE;
        arvalid_nxt = 1'b0;
      end
    endcase
  end

  // Outstanding-read count: AR adds one, accepted R removes one.
  always_comb begin
    outstanding_nxt = outstanding;
    case ({ar_hs, r_acc})
      2'b10:   outstanding_nxt = outstanding + CNT_W'(1);
      2'b01:   outstanding_nxt = outstanding - CNT_W'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      m_arvalid   <= 1'b0;
      m_araddr    <= '0;
      outstanding <= '0;
      load_done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      m_arvalid   <= arvalid_nxt;
      outstanding <= outstanding_nxt;
      load_done   <= (state_nxt == DONE);
      if (araddr_ld) m_araddr <= itcm_auto_load_addr;
    end
  end

  // Read-data forwarding and sticky error flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      IAXI_read_data       <= '0;
      IAXI_read_data_valid <= 1'b0;
      load_err             <= 1'b0;
    end else begin
      IAXI_read_data_valid <= r_acc;
      if (r_acc) IAXI_read_data <= m_rdata;
      load_err <= load_err | r_bad;
    end
  end

endmodule

// File: tb/tb_iaxi_auto_load.sv
// Self-checking bench for iaxi_auto_load with a transaction-level model.
module tb_iaxi_auto_load;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MAXO = 2;
  localparam int unsigned END_ADDR = 32'hC;

  logic clk = 1'b0;
  logic rstn;

  // Primary DUT (MAX_OUTSTANDING=2, last address 0xC)
  logic          itcm_auto_load;
  logic [AW-1:0] itcm_auto_load_addr;
  logic          IAXI_ready;
  logic [DW-1:0] IAXI_read_data;
  logic          IAXI_read_data_valid;
  logic          m_arvalid, m_arready;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_rvalid, m_rready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic          load_done, load_err;

  // Second DUT with default depth, used for the mid-load reset scenario
  logic          b_itcm, b_IAXI_ready, b_valid, b_arvalid, b_arready;
  logic [AW-1:0] b_addr, b_araddr;
  logic [DW-1:0] b_data, b_rdata;
  logic [7:0]    b_arlen;
  logic [2:0]    b_arsize;
  logic [1:0]    b_arburst, b_rresp;
  logic          b_rvalid, b_rready, b_rlast, b_done, b_err;

  iaxi_auto_load #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO),
                   .LOAD_END_ADDR(32'(END_ADDR))) dut (
    .clk(clk), .rstn(rstn), .itcm_auto_load(itcm_auto_load),
    .itcm_auto_load_addr(itcm_auto_load_addr), .IAXI_ready(IAXI_ready),
    .IAXI_read_data(IAXI_read_data), .IAXI_read_data_valid(IAXI_read_data_valid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .load_done(load_done), .load_err(load_err));

  iaxi_auto_load #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut4 (
    .clk(clk), .rstn(rstn), .itcm_auto_load(b_itcm),
    .itcm_auto_load_addr(b_addr), .IAXI_ready(b_IAXI_ready),
    .IAXI_read_data(b_data), .IAXI_read_data_valid(b_valid),
    .m_arvalid(b_arvalid), .m_arready(b_arready), .m_araddr(b_araddr),
    .m_arlen(b_arlen), .m_arsize(b_arsize), .m_arburst(b_arburst),
    .m_rvalid(b_rvalid), .m_rready(b_rready), .m_rdata(b_rdata),
    .m_rresp(b_rresp), .m_rlast(b_rlast), .load_done(b_done), .load_err(b_err));

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  int            base;
  int            ar_count;
  int            beats;
  int            model_out;
  bit            exp_valid;
  logic [DW-1:0] exp_data;
  bit            exp_err;
  bit            hs;
  bit            hs_ready_seen;
  logic [AW-1:0] hs_addr;

  // Apply one cycle of slave stimulus and advance the model across the edge.
  task automatic step(input bit ar_rdy, input bit rv, input logic [DW-1:0] rd,
                      input logic [1:0] rr, input bit rl);
    bit r_ok;
    bit bad;
    m_arready = ar_rdy; m_rvalid = rv; m_rdata = rd; m_rresp = rr; m_rlast = rl;
    #1;
    hs            = m_arvalid && ar_rdy;
    hs_addr       = m_araddr;
    hs_ready_seen = IAXI_ready;
    r_ok          = rv && (model_out > 0);
    bad           = rv && (!r_ok || rr != 2'b00 || !rl);
    @(posedge clk);
    @(negedge clk);
    if (hs) begin ar_count++; model_out++; end
    if (r_ok) begin model_out--; beats++; exp_data = rd; end
    exp_valid = r_ok;
    if (bad) exp_err = 1'b1;
    itcm_auto_load_addr = 32'(base + 4 * ar_count);
  endtask

  task automatic do_reset(input int b);
    rstn = 1'b0;
    itcm_auto_load = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
    m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b1;
    b_itcm = 1'b0; b_addr = '0; b_arready = 1'b0; b_rvalid = 1'b0;
    b_rdata = '0; b_rresp = 2'b00; b_rlast = 1'b1;
    base = b; ar_count = 0; beats = 0; model_out = 0;
    exp_valid = 1'b0; exp_data = '0; exp_err = 1'b0; hs = 1'b0;
    itcm_auto_load_addr = 32'(b);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset(0);
    rstn = 1'b0;
    #1;
    n_total++; if ({m_arvalid, IAXI_ready, IAXI_read_data_valid, load_done, load_err} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {m_arvalid, IAXI_ready, IAXI_read_data_valid, load_done, load_err});
    else n_pass++;
    n_total++; if (m_araddr !== '0 || IAXI_read_data !== '0)
      $display("FAIL reset_regs: araddr %h data %h want 0", m_araddr, IAXI_read_data);
    else n_pass++;
    n_total++; if ({m_arlen, m_arsize, m_arburst, m_rready} !== {8'd0, 3'b010, 2'b01, 1'b1})
      $display("FAIL const_ar: len %h size %b burst %b rready %b", m_arlen, m_arsize, m_arburst, m_rready);
    else n_pass++;
    @(negedge clk); rstn = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (m_arvalid !== 1'b0 || load_done !== 1'b0)
      $display("FAIL idle_hold: arvalid %b done %b want 0 0", m_arvalid, load_done);
    else n_pass++;
  endtask

  task automatic test_basic_load();
    do_reset(0);
    itcm_auto_load = 1'b1;
    for (int i = 0; i < 60 && !load_done; i++) begin
      step(1'b1, model_out > 0, $urandom, 2'b00, 1'b1);
      n_total++; if (hs_ready_seen !== hs) $display("FAIL basic_ready: got %b want %b", hs_ready_seen, hs); else n_pass++;
      if (hs) begin
        n_total++; if (hs_addr !== 32'(base + 4 * (ar_count - 1)))
          $display("FAIL basic_addr: got %h want %h", hs_addr, 32'(base + 4 * (ar_count - 1)));
        else n_pass++;
      end
      n_total++; if (IAXI_read_data_valid !== exp_valid) $display("FAIL basic_valid: got %b want %b", IAXI_read_data_valid, exp_valid); else n_pass++;
      if (exp_valid) begin
        n_total++; if (IAXI_read_data !== exp_data) $display("FAIL basic_data: got %h want %h", IAXI_read_data, exp_data); else n_pass++;
      end
    end
    n_total++; if (load_done !== 1'b1) $display("FAIL basic_done: got %b want 1", load_done); else n_pass++;
    n_total++; if (ar_count != 4 || beats != 4) $display("FAIL basic_counts: ar %0d beats %0d want 4 4", ar_count, beats); else n_pass++;
    n_total++; if (load_err !== 1'b0) $display("FAIL basic_err: got %b want 0", load_err); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset(0);
    itcm_auto_load = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, '0, 2'b00, 1'b1);
      n_total++; if (model_out > int'(MAXO)) $display("FAIL bp_limit: outstanding %0d want <=%0d", model_out, MAXO); else n_pass++;
    end
    n_total++; if (ar_count != 2 || m_arvalid !== 1'b0)
      $display("FAIL bp_stall: ar %0d arvalid %b want 2 0", ar_count, m_arvalid);
    else n_pass++;
    step(1'b1, 1'b1, $urandom, 2'b00, 1'b1);
    for (int i = 0; i < 8 && ar_count < 3; i++) step(1'b1, 1'b0, '0, 2'b00, 1'b1);
    n_total++; if (ar_count != 3 || hs_addr !== 32'h8)
      $display("FAIL bp_resume: ar %0d addr %h want 3 00000008", ar_count, hs_addr);
    else n_pass++;
    for (int i = 0; i < 40 && !load_done; i++) step(1'b1, model_out > 0, $urandom, 2'b00, 1'b1);
    n_total++; if (load_done !== 1'b1 || ar_count != 4 || load_err !== 1'b0)
      $display("FAIL bp_finish: done %b ar %0d err %b want 1 4 0", load_done, ar_count, load_err);
    else n_pass++;
  endtask

  task automatic test_arready_stall();
    int b;
    b = 4 * int'($urandom_range(0, 3));
    do_reset(b);
    itcm_auto_load = 1'b1;
    for (int i = 0; i < 4 && !m_arvalid; i++) step(1'b0, 1'b0, '0, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0, 2'b00, 1'b1);
      n_total++; if (m_arvalid !== 1'b1 || m_araddr !== 32'(b) || hs_ready_seen !== 1'b0)
        $display("FAIL stall_hold: arvalid %b addr %h ready %b want 1 %h 0", m_arvalid, m_araddr, hs_ready_seen, 32'(b));
      else n_pass++;
    end
    step(1'b1, 1'b0, '0, 2'b00, 1'b1);
    n_total++; if (!hs || hs_ready_seen !== 1'b1 || hs_addr !== 32'(b))
      $display("FAIL stall_release: hs %b ready %b addr %h want 1 1 %h", hs, hs_ready_seen, hs_addr, 32'(b));
    else n_pass++;
    for (int i = 0; i < 40 && !load_done; i++) step(1'b1, model_out > 0, $urandom, 2'b00, 1'b1);
    n_total++; if (load_done !== 1'b1 || ar_count != (12 - b) / 4 + 1)
      $display("FAIL stall_finish: done %b ar %0d want 1 %0d", load_done, ar_count, (12 - b) / 4 + 1);
    else n_pass++;
  endtask

  task automatic test_abort();
    // Drop request while in the gap after the first read
    do_reset(0);
    itcm_auto_load = 1'b1;
    for (int i = 0; i < 5 && ar_count == 0; i++) step(1'b1, 1'b0, '0, 2'b00, 1'b1);
    itcm_auto_load = 1'b0;
    for (int i = 0; i < 20 && !load_done; i++) step(1'b1, model_out > 0, $urandom, 2'b00, 1'b1);
    n_total++; if (ar_count != 1 || load_done !== 1'b1)
      $display("FAIL abort_gap: ar %0d done %b want 1 1", ar_count, load_done);
    else n_pass++;
    // Drop request while a read is pending: that read must still complete
    do_reset(0);
    itcm_auto_load = 1'b1;
    for (int i = 0; i < 4 && !m_arvalid; i++) step(1'b0, 1'b0, '0, 2'b00, 1'b1);
    itcm_auto_load = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 2'b00, 1'b1);
    n_total++; if (m_arvalid !== 1'b1) $display("FAIL abort_pending: arvalid %b want 1", m_arvalid); else n_pass++;
    for (int i = 0; i < 20 && !load_done; i++) step(1'b1, model_out > 0, $urandom, 2'b00, 1'b1);
    n_total++; if (ar_count != 1 || load_done !== 1'b1)
      $display("FAIL abort_finish: ar %0d done %b want 1 1", ar_count, load_done);
    else n_pass++;
  endtask

  task automatic test_resp_error();
    int err_i;
    err_i = int'($urandom_range(0, 3));
    do_reset(0);
    itcm_auto_load = 1'b1;
    for (int i = 0; i < 60 && !load_done; i++) begin
      if (model_out > 0 && beats == err_i) step(1'b1, 1'b1, 32'hDEADBEEF, 2'b10, 1'b1);
      else step(1'b1, model_out > 0, $urandom, 2'b00, 1'b1);
      n_total++; if (IAXI_read_data_valid !== exp_valid) $display("FAIL rerr_valid: got %b want %b", IAXI_read_data_valid, exp_valid); else n_pass++;
      if (exp_valid) begin
        n_total++; if (IAXI_read_data !== exp_data) $display("FAIL rerr_data: got %h want %h", IAXI_read_data, exp_data); else n_pass++;
      end
      n_total++; if (load_err !== exp_err) $display("FAIL rerr_flag: got %b want %b", load_err, exp_err); else n_pass++;
    end
    repeat (3) step(1'b1, 1'b0, '0, 2'b00, 1'b1);
    n_total++; if (load_done !== 1'b1 || load_err !== 1'b1)
      $display("FAIL rerr_sticky: done %b err %b want 1 1", load_done, load_err);
    else n_pass++;
  endtask

  task automatic test_spurious();
    do_reset(0);
    step(1'b0, 1'b1, $urandom, 2'b00, 1'b1);
    n_total++; if (IAXI_read_data_valid !== 1'b0 || load_err !== 1'b1 || m_arvalid !== 1'b0)
      $display("FAIL spurious: valid %b err %b arvalid %b want 0 1 0", IAXI_read_data_valid, load_err, m_arvalid);
    else n_pass++;
  endtask

  task automatic test_random_load();
    for (int it = 0; it < 4; it++) begin
      do_reset(4 * int'($urandom_range(0, 3)));
      itcm_auto_load = 1'b1;
      for (int i = 0; i < 300 && !load_done; i++) begin
        step(1'($urandom % 2), (model_out > 0) && ($urandom % 2 == 0), $urandom,
             ($urandom % 8 == 0) ? 2'b10 : 2'b00, ($urandom % 8) != 0);
        if (hs) begin
          n_total++; if (hs_addr !== 32'(base + 4 * (ar_count - 1)))
            $display("FAIL rnd_addr: got %h want %h", hs_addr, 32'(base + 4 * (ar_count - 1)));
          else n_pass++;
        end
        n_total++; if (model_out > int'(MAXO)) $display("FAIL rnd_limit: outstanding %0d want <=%0d", model_out, MAXO); else n_pass++;
        n_total++; if (IAXI_read_data_valid !== exp_valid || (exp_valid && IAXI_read_data !== exp_data))
          $display("FAIL rnd_data: valid %b data %h want %b %h", IAXI_read_data_valid, IAXI_read_data, exp_valid, exp_data);
        else n_pass++;
        n_total++; if (load_err !== exp_err) $display("FAIL rnd_err: got %b want %b", load_err, exp_err); else n_pass++;
      end
      n_total++; if (load_done !== 1'b1 || ar_count != (12 - base) / 4 + 1 || beats != ar_count)
        $display("FAIL rnd_finish: done %b ar %0d beats %0d want 1 %0d %0d", load_done, ar_count, beats, (12 - base) / 4 + 1, (12 - base) / 4 + 1);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    int            pulses;
    bit            sent;
    logic [DW-1:0] d;
    pulses = 0; sent = 1'b0;
    d = $urandom | 32'h1;
    do_reset(0);
    b_itcm = 1'b1; b_arready = 1'b1;
    for (int i = 0; i < 60 && pulses < 4; i++) begin
      @(negedge clk);
      b_addr = 32'(4 * pulses);
      b_rvalid = 1'b0;
      if (pulses == 1 && !sent) begin
        b_rvalid = 1'b1; b_rdata = d; b_rresp = 2'b10; sent = 1'b1;
      end
      if (b_IAXI_ready) pulses++;
    end
    @(posedge clk);
    @(negedge clk);
    b_rvalid = 1'b0;
    n_total++; if (pulses != 4 || b_err !== 1'b1 || b_data !== d)
      $display("FAIL mr_pre: pulses %0d err %b data %h want 4 1 %h", pulses, b_err, b_data, d);
    else n_pass++;
    rstn = 1'b0; b_itcm = 1'b0;
    #1;
    n_total++; if ({b_arvalid, b_IAXI_ready, b_valid, b_done, b_err} !== 5'b0 || b_araddr !== '0 || b_data !== '0)
      $display("FAIL mr_async: flags %b addr %h data %h want 00000 0 0",
               {b_arvalid, b_IAXI_ready, b_valid, b_done, b_err}, b_araddr, b_data);
    else n_pass++;
    @(negedge clk); rstn = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (b_arvalid !== 1'b0 || b_done !== 1'b0)
      $display("FAIL mr_idle: arvalid %b done %b want 0 0", b_arvalid, b_done);
    else n_pass++;
    b_rvalid = 1'b1; b_rresp = 2'b00; b_rlast = 1'b1; b_rdata = $urandom;
    @(negedge clk);
    b_rvalid = 1'b0;
    n_total++; if (b_valid !== 1'b0 || b_err !== 1'b1)
      $display("FAIL mr_late_beat: valid %b err %b want 0 1", b_valid, b_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_backpressure();
    test_arready_stall();
    test_abort();
    test_resp_error();
    test_spurious();
    test_random_load();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/iaxi_auto_load.md
IAXI_AUTO_LOAD -- requirements
Module: iaxi_auto_load

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, range 1..7, maximum accepted-but-unanswered reads.
REQ-004 SHALL have parameter LOAD_END_ADDR, default 32'h0000_7FFC, last word address to fetch.
REQ-005 SHALL have port: clk  input  1  clock.
REQ-006 SHALL have port: rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: itcm_auto_load  input  1  ITCM load in progress.
REQ-008 SHALL have port: itcm_auto_load_addr  input  ADDR_WIDTH  next word address to fetch.
REQ-009 SHALL have port: IAXI_ready  output  1  one-cycle pulse, read request accepted.
REQ-010 SHALL have port: IAXI_read_data  output  DATA_WIDTH  returned word.
REQ-011 SHALL have port: IAXI_read_data_valid  output  1  IAXI_read_data qualifier.
REQ-012 SHALL have ports: m_arvalid out 1; m_arready in 1; m_araddr out ADDR_WIDTH; m_arlen out 8; m_arsize out 3; m_arburst out 2.
REQ-013 SHALL have ports: m_rvalid in 1; m_rready out 1; m_rdata in DATA_WIDTH; m_rresp in 2; m_rlast in 1.
REQ-014 SHALL have ports: load_done out 1, all fetches answered; load_err out 1, sticky error flag.

Function
REQ-015 SHALL drive m_arlen=0, m_arsize=3'b010, m_arburst=2'b01 constantly (single-beat word reads).
REQ-016 SHALL implement FSM IDLE, LOAD, GAP, DRAIN, DONE; reset state IDLE.
REQ-017 IDLE->LOAD SHALL occur when itcm_auto_load=1; m_araddr loads itcm_auto_load_addr on that edge.
REQ-018 In LOAD, m_arvalid SHALL be 1 only while outstanding<MAX_OUTSTANDING; once raised it SHALL stay high with m_araddr stable until m_arready.
REQ-019 On AR handshake, IAXI_ready SHALL be 1 that same cycle (combinational from handshake), outstanding increments.
REQ-020 After handshake with m_araddr!=LOAD_END_ADDR: ->GAP for exactly one cycle, m_arvalid=0, m_araddr reloads itcm_auto_load_addr at GAP exit, ->LOAD; peak rate one AR per 2 cycles.
REQ-021 After handshake with m_araddr==LOAD_END_ADDR: ->DRAIN, no further AR issued.
REQ-022 itcm_auto_load=0 in LOAD with m_arvalid=0 or GAP: ->DRAIN; in LOAD with m_arvalid=1 the pending request SHALL complete first.
REQ-023 DRAIN->DONE when outstanding==0; DONE holds until reset; load_done=1 only in DONE.
REQ-024 m_rready SHALL be constant 1.
REQ-025 R handshake with outstanding>0: next cycle IAXI_read_data=m_rdata, IAXI_read_data_valid=1 for one cycle; outstanding decrements; in-order.
REQ-026 Simultaneous AR and R handshake: outstanding unchanged.
REQ-027 m_rresp!=2'b00 or m_rlast=0 on an accepted beat: data still forwarded, load_err set sticky.
REQ-028 R handshake with outstanding==0: beat dropped (no valid), load_err set, counter stays 0 (no underflow).
REQ-029 Outstanding counter SHALL be 3 bits, never exceed MAX_OUTSTANDING.

Reset
REQ-030 On rstn low, SHALL asynchronously clear: state IDLE, m_arvalid 0, m_araddr 0, IAXI_ready 0, IAXI_read_data 0, IAXI_read_data_valid 0, outstanding 0, load_err 0, load_done 0.
REQ-031 Reset mid-load SHALL abandon outstanding reads; beats arriving after release with outstanding==0 follow REQ-028.

Verification
REQ-032 LOAD_END_ADDR=0xC, arready=1, R one cycle after AR, rresp=0 -> AR at 0x0,0x4,0x8,0xC; 4 IAXI_ready pulses; 4 data valids in order; load_done=1; load_err=0.
REQ-033 MAX_OUTSTANDING=2, R withheld -> exactly 2 ARs, m_arvalid low; one R beat -> third AR issued.
REQ-034 arready held 0 for 5 cycles -> m_arvalid and m_araddr stable 5 cycles, no IAXI_ready pulse.
REQ-035 One beat rresp=2'b10, rdata=0xDEADBEEF -> IAXI_read_data=0xDEADBEEF with valid, load_err=1 sticky through DONE.
REQ-036 Spurious rvalid at outstanding=0 -> no IAXI_read_data_valid, load_err=1; rstn pulse mid-load with 3 outstanding -> all outputs 0, state IDLE.
